conv_job_sequencer: RTL
=======================

# conv_job_sequencer

Host-side initiator for the convolution engine's `ps_control`/`pl_status` job handshake, and the reader of the output BRAM's controller port B.
- Accepts one job descriptor: bias, kernel size k, output size c, and channel-pass count n.
- Runs n accumulate passes, stepping `n_val` from 0 to n-1 with one full four-phase handshake per pass.
- Then drains the c*c result words from the output BRAM into a valid/ready stream.
- Replaces software polling of the control/status registers.

## Interface
- `T`, 32: data/address/register width.
- `RD_LAT`, 2: output-BRAM port-B read latency in cycles (≥1).
- `TIMEOUT`, 1048576: cycles allowed per handshake phase before abort.
- One clock; reset is asynchronous and active-high.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1; `cmd_ready` out 1: job descriptor handshake.
- `cmd_bias`, `cmd_k`, `cmd_c`, `cmd_n` in T each: descriptor fields.
- `ps_control` out T: job request to the engine; only bit 0 is ever set.
- `pl_status` in T: engine completion flag; compared as whole word (==0 / ==1).
- `bias`, `k_val`, `c_val`, `n_val` out T: job registers presented to the engine.
- `bram_oc_en` out 1; `bram_oc_we` out 4; `bram_oc_addr` out T; `bram_oc_wrdata` out T: output BRAM port B.
- `bram_oc_rddata` in T: output BRAM port B read data.
- `m_valid` out 1; `m_ready` in 1; `m_data` out T; `m_last` out 1: result stream.
- `busy` out 1; `done` out 1 (one-cycle pulse); `err` out 1 (sticky timeout flag).

## Operation
- States: IDLE, RUN, RELEASE, DRAIN_RD, DRAIN_WAIT, DRAIN_OUT, DONE.
- IDLE
  - `cmd_ready`=1 only in IDLE.
  - On accept: latch descriptor, clear `err`, pass=0.
  - If `cmd_n`==0 or `cmd_c`==0, go to DONE with no handshake and no beats; otherwise go to RUN.
- RUN: `ps_control`=1, `n_val`=pass; wait for `pl_status`==1, then go to RELEASE.
- RELEASE: `ps_control`=0; wait for `pl_status`==0.
  - If pass+1 < n: pass++ and go to RUN.
  - Otherwise set `n_val`=1 (the readback key that opens the engine's port-B path), idx=0, and go to DRAIN_RD.
- DRAIN_RD: `bram_oc_addr`=idx*4; go to DRAIN_WAIT.
- DRAIN_WAIT: count RD_LAT cycles, capture `bram_oc_rddata` into `m_data`, go to DRAIN_OUT.
- DRAIN_OUT: `m_valid`=1, `m_last`=(idx==c*c-1).
  - On `m_ready`, if last go to DONE; otherwise idx++ and go to DRAIN_RD.
- DONE: `done`=1 for one cycle, then IDLE.
- Timeout
  - A phase counter runs in RUN and RELEASE and clears on every transition.
  - At TIMEOUT-1: set `err`=1, `ps_control`=0, go to DONE; the drain is skipped.
- Arithmetic
  - c*c is computed in T bits, truncated.
  - idx is T bits; the byte address idx*4 wraps modulo 2^T.
  - pass is T bits.
- Constant outputs: `bram_oc_we`=0 and `bram_oc_wrdata`=0 at all times.
- `bram_oc_en`=1 throughout the DRAIN_* states, 0 elsewhere.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: state IDLE, `ps_control`=0, `bias`=`k_val`=`c_val`=`n_val`=0, `bram_oc_en`=0, `bram_oc_addr`=0, `m_valid`=`m_last`=0, `m_data`=0, `done`=0, `err`=0, `busy`=0.
  - `cmd_ready`=1 from the first cycle after reset deasserts.
- All outputs are registered. Command accepted at edge E → `ps_control`=1 and `n_val`=0 visible after E+1.
- `pl_status` is sampled at each edge; a response is visible one cycle later.
- Between passes, `n_val` and `ps_control`=1 change in the same cycle. `ps_control` stays 0 for at least one cycle after `pl_status`==0 is seen.
- Drain throughput: one word per RD_LAT+2 cycles with `m_ready` held high.
  - `m_data` and `m_last` stay stable while `m_valid` && !`m_ready`.
  - `m_valid` never drops without a transfer.
- Reset mid-job: the immediate asynchronous return to reset values is required.
  - The engine may be left with `pl_status`=1; the next RUN sees `pl_status`==1 at once.
  - Software must reset the engine together with this block.
- `pl_status` already 1 on entry to RUN: go to RELEASE the next cycle.
- `cmd_valid` while busy: ignored and held off by `cmd_ready`=0.

## Structure
- Package `dnn_seq_pkg`:
  - `seq_state_t` enum.
  - `BYTES_PER_WORD`=4.
  - `READBACK_N_VAL`=1.
  - `CTRL_GO`=1.
- One sub-module is natural: `oc_readback_port`, covering DRAIN_RD, DRAIN_WAIT, DRAIN_OUT.
  - Inputs: word count, start.
  - Outputs: `bram_oc_*`, the stream, finished.
- The top level holds the handshake FSM and the timeout counter.

## Test plan
- Descriptor k=3, c=4, n=2, bias=0x3F800000; engine model responds 5 cycles after request → expect:
  - two handshakes, with `n_val`=0 then `n_val`=1;
  - 16 beats at addresses 0x00..0x3C with `m_last` only on beat 16;
  - one `done` pulse.
- `m_ready` toggling randomly during drain → `m_data` stable while stalled, no beat lost or duplicated, beat count=16.
- `cmd_n`=0 (and separately `cmd_c`=0) → no `ps_control` assertion, zero beats, `done` one cycle after DONE entry.
- Engine never raises `pl_status`, TIMEOUT=64 → `err`=1 and `ps_control`=0 after 64 RUN cycles, no drain, `done` pulse; the next command clears `err`.
- Reset asserted during beat 7 of a drain → all outputs at reset values asynchronously; a new job afterwards completes normally.
- RD_LAT=1 vs RD_LAT=2 builds → `m_data` equals the BRAM model contents at idx*4 for every beat.

Source files
------------

// File: rtl/conv_job_sequencer_pkg.sv
// dnn_seq_pkg: state encoding and constants shared by the convolution job sequencer.
package dnn_seq_pkg;
  typedef enum logic [2:0] {IDLE, RUN, RELEASE, DRAIN_RD, DRAIN_WAIT, DRAIN_OUT, DONE} seq_state_t;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned READBACK_N_VAL = 1;
  localparam int unsigned CTRL_GO = 1;
endpackage

// File: rtl/conv_job_sequencer_if.sv
// conv_job_sequencer_if: job command, engine handshake, output-BRAM port B and result stream.
interface conv_job_sequencer_if #(parameter int unsigned T = 32);
  logic         cmd_valid, cmd_ready;
  logic [T-1:0] cmd_bias, cmd_k, cmd_c, cmd_n;
  logic [T-1:0] ps_control, pl_status, bias, k_val, c_val, n_val;
  logic         bram_oc_en;
  logic [3:0]   bram_oc_we;
  logic [T-1:0] bram_oc_addr, bram_oc_wrdata, bram_oc_rddata;
  logic         m_valid, m_ready, m_last;
  logic [T-1:0] m_data;
  logic         busy, done, err;
  modport master (
    input  cmd_valid, cmd_bias, cmd_k, cmd_c, cmd_n, pl_status, bram_oc_rddata, m_ready,
    output cmd_ready, ps_control, bias, k_val, c_val, n_val, bram_oc_en, bram_oc_we,
           bram_oc_addr, bram_oc_wrdata, m_valid, m_data, m_last, busy, done, err
  );
  modport slave (
    output cmd_valid, cmd_bias, cmd_k, cmd_c, cmd_n, pl_status, bram_oc_rddata, m_ready,
    input  cmd_ready, ps_control, bias, k_val, c_val, n_val, bram_oc_en, bram_oc_we,
           bram_oc_addr, bram_oc_wrdata, m_valid, m_data, m_last, busy, done, err
  );
endinterface

// File: rtl/conv_job_sequencer_oc_readback_port.sv
// oc_readback_port: drains words from output-BRAM port B into a valid/ready stream, one read in flight.
module oc_readback_port
  import dnn_seq_pkg::*;
#(
  parameter int unsigned T      = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [T-1:0] words,
  output logic         bram_oc_en,
  output logic [3:0]   bram_oc_we,
  output logic [T-1:0] bram_oc_addr,
  output logic [T-1:0] bram_oc_wrdata,
  input  logic [T-1:0] bram_oc_rddata,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [T-1:0] m_data,
  output logic         m_last,
  output logic         finished
);
  localparam int unsigned LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  seq_state_t state, state_n;
  logic [T-1:0] idx;
  logic [LW-1:0] lat;
  logic last;
  assign bram_oc_we = '0;
  assign bram_oc_wrdata = '0;
  assign last = idx == words - 1'b1;
  assign finished = state == DRAIN_OUT && m_ready && last;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = start ? DRAIN_RD : IDLE;
      DRAIN_RD:   state_n = DRAIN_WAIT;
      DRAIN_WAIT: state_n = lat == LW'(RD_LAT - 1) ? DRAIN_OUT : DRAIN_WAIT;
      DRAIN_OUT:  state_n = !m_ready ? DRAIN_OUT : last ? IDLE : DRAIN_RD;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      lat <= '0;
      bram_oc_en <= 1'b0;
      bram_oc_addr <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
    end else begin
      state <= state_n;
      bram_oc_en <= state_n inside {DRAIN_RD, DRAIN_WAIT, DRAIN_OUT};
      m_valid <= state_n == DRAIN_OUT;
      m_last <= state_n == DRAIN_OUT && last;
      lat <= state == DRAIN_WAIT ? lat + 1'b1 : '0;
      if (state == IDLE && start) begin
        idx <= '0;
        bram_oc_addr <= '0;
      end
      if (state == DRAIN_OUT && m_ready && !last) begin
        idx <= idx + 1'b1;
        bram_oc_addr <= (idx + 1'b1) * T'(BYTES_PER_WORD);
      end
      if (state == DRAIN_WAIT && state_n == DRAIN_OUT) m_data <= bram_oc_rddata;
    end
  end
endmodule

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: runs n ps_control/pl_status handshakes per job, then drains c*c result words.
module conv_job_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int unsigned T       = 32,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned TIMEOUT = 1048576
) (
  input logic clk,
  input logic reset,
  conv_job_sequencer_if.master bus
);
  seq_state_t state, state_n;
  logic [T-1:0] n_jobs, words;
  logic [31:0] tcnt;
  logic more, timeout, start, finished;
  assign words = bus.c_val * bus.c_val;
  assign more = bus.n_val + 1'b1 < n_jobs;
  assign timeout = tcnt == TIMEOUT - 1;
  assign start = state == RELEASE && bus.pl_status == '0 && !more;
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.ps_control = {{(T-1){1'b0}}, state == RUN};
  // DRAIN_RD stands for the whole drain here; the readback port owns its sub-phases.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (bus.cmd_valid) state_n = (bus.cmd_n == '0 || bus.cmd_c == '0) ? DONE : RUN;
      RUN:      state_n = bus.pl_status == T'(CTRL_GO) ? RELEASE : timeout ? DONE : RUN;
      RELEASE:  state_n = bus.pl_status == '0 ? (more ? RUN : DRAIN_RD) : timeout ? DONE : RELEASE;
      DRAIN_RD: state_n = finished ? DONE : DRAIN_RD;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      n_jobs <= '0;
      bus.bias <= '0;
      bus.k_val <= '0;
      bus.c_val <= '0;
      bus.n_val <= '0;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= (state_n == state && (state == RUN || state == RELEASE)) ? tcnt + 1'b1 : '0;
      if (state == IDLE && bus.cmd_valid) begin
        bus.bias <= bus.cmd_bias;
        bus.k_val <= bus.cmd_k;
        bus.c_val <= bus.cmd_c;
        n_jobs <= bus.cmd_n;
        bus.n_val <= '0;
        bus.err <= 1'b0;
      end
      if (state == RELEASE && state_n == RUN) bus.n_val <= bus.n_val + 1'b1;
      if (start) bus.n_val <= T'(READBACK_N_VAL);
      if ((state == RUN || state == RELEASE) && state_n == DONE) bus.err <= 1'b1;
    end
  end
  oc_readback_port #(.T(T), .RD_LAT(RD_LAT)) u_readback (
    .clk(clk),
    .reset(reset),
    .start(start),
    .words(words),
    .bram_oc_en(bus.bram_oc_en),
    .bram_oc_we(bus.bram_oc_we),
    .bram_oc_addr(bus.bram_oc_addr),
    .bram_oc_wrdata(bus.bram_oc_wrdata),
    .bram_oc_rddata(bus.bram_oc_rddata),
    .m_valid(bus.m_valid),
    .m_ready(bus.m_ready),
    .m_data(bus.m_data),
    .m_last(bus.m_last),
    .finished(finished)
  );
endmodule
